// File: rtl/iir_sos_cascade.sv
// Cascade of Direct Form I biquad sections time-sharing one multiplier/accumulator.
// Coefficients (b0,b1,b2,a1,a2 per section) are run-time writable; a0 is implicitly 1.0.
module iir_sos_cascade #(
  parameter int Ndint  = 3,
  parameter int Ndfrac = 22,
  parameter int Ncint  = 4,
  parameter int Ncfrac = 14,
  parameter int Nsec   = 4,
  parameter int Nguard = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [Ndint+Ndfrac-1:0]       d_in,
  output logic                          out_valid,
  output logic [Ndint+Ndfrac-1:0]       d_out,
  output logic                          sat_flag,
  input  logic                          clear,
  input  logic                          coef_we,
  input  logic [$clog2(5*Nsec)-1:0]     coef_addr,
  input  logic [Ncint+Ncfrac-1:0]       coef_data,
  output logic                          coef_err
);

  localparam int DW   = Ndint + Ndfrac;
  localparam int CW   = Ncint + Ncfrac;
  localparam int NC   = 5 * Nsec;
  localparam int AW   = $clog2(NC);
  localparam int SW   = (Nsec > 1) ? $clog2(Nsec) : 1;
  localparam int ACCW = Ndint + Ncint + Nguard + Ndfrac + Ncfrac;
  localparam int RW   = ACCW - Ncfrac;

  localparam logic [CW-1:0]          COEF_ONE = {{(CW-1){1'b0}}, 1'b1} << Ncfrac;
  localparam logic signed [ACCW-1:0] HALF     = {{(ACCW-1){1'b0}}, 1'b1} << (Ncfrac - 1);
  localparam logic [DW-1:0]          DMAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]          DMIN     = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_t;

  state_t                  state;
  logic [SW-1:0]           sec;
  logic [2:0]              k;
  logic signed [ACCW-1:0]  acc;
  logic signed [DW-1:0]    x_cur;
  logic signed [DW-1:0]    x1 [Nsec];
  logic signed [DW-1:0]    x2 [Nsec];
  logic signed [DW-1:0]    y1 [Nsec];
  logic signed [DW-1:0]    y2 [Nsec];
  logic signed [CW-1:0]    coef [NC];
  logic                    sat_any;
  logic                    pend_we;
  logic [AW-1:0]           pend_addr;
  logic [CW-1:0]           pend_data;

  logic [AW-1:0]           cidx;
  logic signed [DW-1:0]    opd;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  rnd;
  logic [RW-1:0]           rsh;
  logic                    ovf;
  logic signed [DW-1:0]    res;
  logic                    accept;
  logic                    coef_ok;

  always_comb begin
    cidx = AW'(5 * int'(sec) + int'(k));
    case (k)
      3'd0:    opd = x_cur;
      3'd1:    opd = x1[sec];
      3'd2:    opd = x2[sec];
      3'd3:    opd = y1[sec];
      default: opd = y2[sec];
    endcase
    // Full product always fits in the accumulator width, so the wide multiply is exact.
    prod_ext = ACCW'(opd) * ACCW'(coef[cidx]);
    rnd      = acc + HALF;
    rsh      = RW'(rnd >>> Ncfrac);
    ovf      = !((&rsh[RW-1:DW-1]) || !(|rsh[RW-1:DW-1]));
    res      = ovf ? (rsh[RW-1] ? DMIN : DMAX) : rsh[DW-1:0];
    accept   = in_valid && in_ready && !clear;
    coef_ok  = in_ready && (int'(coef_addr) < NC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sec       <= '0;
      k         <= '0;
      acc       <= '0;
      x_cur     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      d_out     <= '0;
      sat_flag  <= 1'b0;
      sat_any   <= 1'b0;
      coef_err  <= 1'b0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      for (int s = 0; s < Nsec; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
      end
      for (int i = 0; i < NC; i++) begin
        coef[i] <= (i % 5 == 0) ? COEF_ONE : '0;
      end
    end else begin
      out_valid <= 1'b0;
      coef_err  <= 1'b0;

      // A write landing with an accept is deferred so that sample sees the old value.
      if (coef_we) begin
        if (!coef_ok) begin
          coef_err <= 1'b1;
        end else if (accept) begin
          pend_we   <= 1'b1;
          pend_addr <= coef_addr;
          pend_data <= coef_data;
        end else begin
          coef[coef_addr] <= coef_data;
        end
      end

      if (clear) begin
        state    <= IDLE;
        in_ready <= 1'b1;
        sat_any  <= 1'b0;
        sec      <= '0;
        k        <= '0;
        for (int s = 0; s < Nsec; s++) begin
          x1[s] <= '0;
          x2[s] <= '0;
          y1[s] <= '0;
          y2[s] <= '0;
        end
        if (pend_we) begin
          coef[pend_addr] <= pend_data;
          pend_we         <= 1'b0;
        end
      end else begin
        case (state)
          IDLE, DONE: begin
            if (accept) begin
              x_cur    <= d_in;
              in_ready <= 1'b0;
              sec      <= '0;
              k        <= '0;
              sat_any  <= 1'b0;
              state    <= MAC;
            end else begin
              state <= IDLE;
            end
          end
          MAC: begin
            if (k == 3'd0)      acc <= prod_ext;
            else if (k < 3'd3)  acc <= acc + prod_ext;
            else                acc <= acc - prod_ext;
            if (k == 3'd4) state <= SAT;
            else           k     <= k + 3'd1;
          end
          SAT: begin
            x2[sec] <= x1[sec];
            x1[sec] <= x_cur;
            y2[sec] <= y1[sec];
            y1[sec] <= res;
            x_cur   <= res;
            k       <= '0;
            if (int'(sec) == Nsec - 1) begin
              state     <= DONE;
              out_valid <= 1'b1;
              d_out     <= res;
              sat_flag  <= sat_any | ovf;
              in_ready  <= 1'b1;
              if (pend_we) begin
                coef[pend_addr] <= pend_data;
                pend_we         <= 1'b0;
              end
            end else begin
              sat_any <= sat_any | ovf;
              sec     <= sec + 1'b1;
              state   <= MAC;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Self-checking bench for iir_sos_cascade: integer reference model feeds a scoreboard
// that is drained by an out_valid monitor; scenario tasks add timing and protocol checks.
module tb_iir_sos_cascade;
  localparam int NSEC = 4;
  localparam int DW   = 25;
  localparam int CW   = 18;
  localparam int NC   = 5 * NSEC;
  localparam int AW   = $clog2(NC);
  localparam int LAT  = 6 * NSEC + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] d_in = '0;
  logic          out_valid;
  logic [DW-1:0] d_out;
  logic          sat_flag;
  logic          clear = 1'b0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          coef_err;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  logic [DW-1:0] last_out = '0;
  logic          last_sat = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic          exp_sat_q[$];
  logic [DW-1:0] e;
  logic          es;

  longint mc [NC];
  longint mx1 [NSEC];
  longint mx2 [NSEC];
  longint my1 [NSEC];
  longint my2 [NSEC];

  always #5 clk = ~clk;

  iir_sos_cascade #(.Nsec(NSEC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d_in(d_in),
    .out_valid(out_valid), .d_out(d_out), .sat_flag(sat_flag), .clear(clear),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err)
  );

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      out_count++;
      last_out = d_out;
      last_sat = sat_flag;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: d_out=%h with no sample outstanding", d_out);
      end else begin
        e  = exp_q.pop_front();
        es = exp_sat_q.pop_front();
        if (d_out !== e) begin
          errors++;
          $display("FAIL sb_d_out: got %h expected %h", d_out, e);
        end
        checks++;
        if (sat_flag !== es) begin
          errors++;
          $display("FAIL sb_sat_flag: got %b expected %b", sat_flag, es);
        end
      end
    end
  end

  task automatic model_clear_hist();
    for (int s = 0; s < NSEC; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endtask

  task automatic model_passthrough();
    for (int i = 0; i < NC; i++) mc[i] = (i % 5 == 0) ? 64'sd16384 : 64'sd0;
  endtask

  task automatic model_push(input logic [DW-1:0] xin);
    longint x, acc, r;
    bit sat;
    sat = 0;
    x = longint'($signed(xin));
    for (int s = 0; s < NSEC; s++) begin
      acc = mc[5*s]*x + mc[5*s+1]*mx1[s] + mc[5*s+2]*mx2[s]
            - mc[5*s+3]*my1[s] - mc[5*s+4]*my2[s];
      r = (acc + 64'sd8192) >>> 14;
      if (r > 64'sd16777215) begin r = 64'sd16777215; sat = 1; end
      else if (r < -64'sd16777216) begin r = -64'sd16777216; sat = 1; end
      mx2[s] = mx1[s]; mx1[s] = x;
      my2[s] = my1[s]; my1[s] = r;
      x = r;
    end
    exp_q.push_back(DW'(x));
    exp_sat_q.push_back(sat);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_coef(input int addr, input logic [CW-1:0] data);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = data;
    tick();
    coef_we = 1'b0;
    mc[addr] = longint'($signed(data));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear_hist();
  endtask

  task automatic send(input logic [DW-1:0] x);
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    in_valid = 1'b1; d_in = x;
    model_push(x);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic load_impulse_coefs();
    set_coef(0, 18'sd1599);
    set_coef(1, 18'sd3199);
    set_coef(2, 18'sd1599);
    set_coef(3, -18'sd15447);
    set_coef(4, 18'sd5461);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_passthrough();
    model_clear_hist();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_d_out: got %h expected 0", d_out); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
    checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL reset_coef_err: got %b expected 0", coef_err); end
  endtask

  task automatic test_passthrough();
    int n;
    in_valid = 1'b1; d_in = 25'h0200000;
    model_push(25'h0200000);
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
    n = 1;
    while (!out_valid && n < 100) begin tick(); n++; end
    checks++; if (n != LAT) begin errors++; $display("FAIL latency: out_valid at cycle %0d expected %0d", n, LAT); end
    checks++; if (d_out !== 25'h0200000) begin errors++; $display("FAIL passthrough_value: got %h expected 0200000", d_out); end
    drain();
  endtask

  task automatic test_impulse();
    load_impulse_coefs();
    do_clear();
    send(25'h0400000);
    drain();
    checks++; if (last_out !== 25'd409344) begin errors++; $display("FAIL impulse_first: got %0d expected 409344", last_out); end
    for (int i = 0; i < 8; i++) send('0);
    drain();
  endtask

  task automatic test_saturation();
    for (int s = 0; s < NSEC; s++) begin
      set_coef(5*s, 18'h1C000);
      for (int j = 1; j < 5; j++) set_coef(5*s+j, '0);
    end
    do_clear();
    send(25'h0C00000);
    drain();
    checks++; if (last_out !== 25'h0FFFFFF) begin errors++; $display("FAIL sat_max: got %h expected 0FFFFFF", last_out); end
    checks++; if (last_sat !== 1'b1) begin errors++; $display("FAIL sat_max_flag: got %b expected 1", last_sat); end
    send(25'h1000000);
    drain();
    checks++; if (last_out !== 25'h1000000) begin errors++; $display("FAIL sat_min: got %h expected 1000000", last_out); end
    checks++; if (last_sat !== 1'b1) begin errors++; $display("FAIL sat_min_flag: got %b expected 1", last_sat); end
    for (int s = 0; s < NSEC; s++) set_coef(5*s, 18'h04000);
    do_clear();
    send(25'h0123456);
    drain();
    checks++; if (last_out !== 25'h0123456) begin errors++; $display("FAIL nosat_value: got %h expected 0123456", last_out); end
    checks++; if (last_sat !== 1'b0) begin errors++; $display("FAIL nosat_flag: got %b expected 0", last_sat); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int last_acc = -1;
    int start = out_count;
    in_valid = 1'b1; d_in = 25'h00ABCDE;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        accepts++;
        last_acc = i;
        model_push(d_in);
      end
      tick();
    end
    in_valid = 1'b0;
    drain();
    checks++; if (accepts != 4) begin errors++; $display("FAIL b2b_accepts: got %0d expected 4", accepts); end
    checks++; if (last_acc != 3*LAT) begin errors++; $display("FAIL b2b_spacing: last accept at %0d expected %0d", last_acc, 3*LAT); end
    checks++; if (out_count - start != 4) begin errors++; $display("FAIL b2b_outputs: got %0d expected 4", out_count - start); end
  endtask

  task automatic test_clear();
    int start;
    load_impulse_coefs();
    do_clear();
    start = out_count;
    in_valid = 1'b1; d_in = 25'h0300000;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    do_clear();
    repeat (40) tick();
    checks++; if (out_count != start) begin errors++; $display("FAIL clear_abort: %0d out_valid pulses expected 0", out_count - start); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %b expected 1", in_ready); end
    clear = 1'b1; in_valid = 1'b1; d_in = 25'h0200000;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_wins_ready: got %b expected 1", in_ready); end
    repeat (30) tick();
    checks++; if (out_count != start) begin errors++; $display("FAIL clear_wins_output: %0d pulses expected 0", out_count - start); end
    send(25'h0400000);
    drain();
    checks++; if (last_out !== 25'd409344) begin errors++; $display("FAIL clear_impulse_first: got %0d expected 409344", last_out); end
    for (int i = 0; i < 4; i++) send('0);
    drain();
  endtask

  task automatic test_coef_err();
    do_clear();
    send(25'h0100000);
    coef_we = 1'b1; coef_addr = AW'(0); coef_data = '0;
    tick();
    coef_we = 1'b0;
    checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL err_busy: got %b expected 1", coef_err); end
    tick();
    checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", coef_err); end
    drain();
    coef_we = 1'b1; coef_addr = AW'(NC); coef_data = 18'h04000;
    tick();
    coef_we = 1'b0;
    checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL err_addr: got %b expected 1", coef_err); end
    // write and accept on the same edge: this sample must see the old b0
    in_valid = 1'b1; d_in = 25'h0400000;
    coef_we = 1'b1; coef_addr = AW'(0); coef_data = 18'h02000;
    model_push(25'h0400000);
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    mc[0] = 64'sd8192;
    checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL err_legal: got %b expected 0", coef_err); end
    drain();
    do_clear();
    send(25'h0400000);
    send(25'h0);
    send(25'h1F00000);
    drain();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_impulse();
    test_saturation();
    test_back_to_back();
    test_clear();
    test_coef_err();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
